// File: rtl/quant_rle.sv
// quant_rle: fetches a 64-coefficient block from a shared RAM in scan order,
// quantises each coefficient by a right shift of its magnitude, and emits
// (run, level) beats for nonzero levels followed by a single end-of-block beat.
// Optional build macro: QUANT_RLE_ZIGZAG_EN selects the MPEG-2 zigzag scan
// order; when undefined the block scans in raster order.
module quant_rle (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic        rdy,
    input  logic [3:0]  qshift,
    output logic [5:0]  addr,
    input  logic [15:0] q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_run,
    output logic [11:0] out_level,
    output logic        out_eob
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_QUANT = 3'd2,
        S_EMIT  = 3'd3,
        S_EOB   = 3'd4
    } state_t;

    typedef struct packed {
        logic        eob;
        logic [5:0]  run;
        logic [11:0] level;
    } beat_t;

`ifdef QUANT_RLE_ZIGZAG_EN
    localparam logic [5:0] ZZ_TAB [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] scan(input logic [5:0] i);
        return ZZ_TAB[i];
    endfunction
`else
    function automatic logic [5:0] scan(input logic [5:0] i);
        return i;
    endfunction
`endif

    state_t      state, state_nxt;
    logic [5:0]  addr_nxt;
    logic [6:0]  idx, idx_nxt, idx_inc;
    logic [5:0]  run, run_nxt;
    logic [3:0]  qsh, qsh_nxt;
    logic        vld_nxt;
    beat_t       beat, beat_nxt;
    logic        last;

    // quantiser datapath: shift the magnitude, saturate, then reapply sign
    logic [15:0] mag_abs;
    logic [15:0] mag_sh;
    logic [10:0] mag_sat;
    logic [11:0] level;

    // -32768 negates to 16'h8000, which reads correctly as unsigned 32768
    assign mag_abs = q[15] ? (~q + 16'd1) : q;
    assign mag_sh  = mag_abs >> qsh;
    assign mag_sat = (mag_sh > 16'd2047) ? 11'd2047 : mag_sh[10:0];
    assign level   = q[15] ? (12'd0 - {1'b0, mag_sat}) : {1'b0, mag_sat};

    assign idx_inc = idx + 7'd1;
    assign last    = (idx == 7'd63);

    assign rdy       = (state == S_IDLE);
    assign out_eob   = beat.eob;
    assign out_run   = beat.run;
    assign out_level = beat.level;

    // next-state and next-register values for the whole block
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        idx_nxt   = idx;
        run_nxt   = run;
        qsh_nxt   = qsh;
        vld_nxt   = out_valid;
        beat_nxt  = beat;
        case (state)
            S_IDLE: begin
                if (en) begin
                    qsh_nxt   = qshift;
                    idx_nxt   = 7'd0;
                    run_nxt   = 6'd0;
                    addr_nxt  = scan(6'd0);
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_QUANT;
            end
            S_QUANT: begin
                if (level == 12'd0) begin
                    run_nxt = run + 6'd1;
                    if (last) begin
                        vld_nxt   = 1'b1;
                        beat_nxt  = '{eob: 1'b1, run: 6'd0, level: 12'd0};
                        state_nxt = S_EOB;
                    end else begin
                        idx_nxt   = idx_inc;
                        addr_nxt  = scan(idx_inc[5:0]);
                        state_nxt = S_FETCH;
                    end
                end else begin
                    vld_nxt   = 1'b1;
                    beat_nxt  = '{eob: 1'b0, run: run, level: level};
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    run_nxt = 6'd0;
                    if (last) begin
                        // valid stays up: the EOB beat follows directly
                        beat_nxt  = '{eob: 1'b1, run: 6'd0, level: 12'd0};
                        state_nxt = S_EOB;
                    end else begin
                        vld_nxt   = 1'b0;
                        idx_nxt   = idx_inc;
                        addr_nxt  = scan(idx_inc[5:0]);
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_EOB: begin
                if (out_ready) begin
                    vld_nxt   = 1'b0;
                    beat_nxt  = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                vld_nxt   = 1'b0;
                beat_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr      <= 6'd0;
            idx       <= 7'd0;
            run       <= 6'd0;
            qsh       <= 4'd0;
            out_valid <= 1'b0;
            beat      <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            idx       <= idx_nxt;
            run       <= run_nxt;
            qsh       <= qsh_nxt;
            out_valid <= vld_nxt;
            beat      <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_quant_rle.sv
// tb_quant_rle: table vectors, hand sequences and randomized blocks checked
// against a scan/quantise/run-length reference model.
module tb_quant_rle;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        rdy;
    logic [3:0]  qshift = 4'd0;
    logic [5:0]  addr;
    logic [15:0] q = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_run;
    logic [11:0] out_level;
    logic        out_eob;

    quant_rle dut (
        .clk(clk), .reset_n(reset_n), .en(en), .rdy(rdy), .qshift(qshift),
        .addr(addr), .q(q), .out_valid(out_valid), .out_ready(out_ready),
        .out_run(out_run), .out_level(out_level), .out_eob(out_eob)
    );

    always #5 clk = ~clk;

    // shared coefficient RAM with one-cycle read latency
    logic [15:0] mem [64];
    always @(posedge clk) q <= mem[addr];

    typedef struct packed {
        logic        eob;
        logic [5:0]  run;
        logic [11:0] level;
    } beat_t;

    typedef struct {
        int coef;
        int qs;
        int lvl;
    } vec_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int checks = 0;
    int failures = 0;

`ifdef QUANT_RLE_ZIGZAG_EN
    localparam int ZZ [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    function automatic int tb_scan(input int i);
        return ZZ[i];
    endfunction
`else
    function automatic int tb_scan(input int i);
        return i;
    endfunction
`endif

    function automatic beat_t mk(input int e, input int r, input int l);
        beat_t b;
        b.eob   = e[0];
        b.run   = r[5:0];
        b.level = l[11:0];
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // reference: walk the scan, quantise with integer math, count zero runs
    task automatic model(input int qs);
        int zeros, v, m;
        zeros = 0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            v = int'($signed(mem[tb_scan(i)]));
            m = (v < 0) ? -v : v;
            m = m >> qs;
            if (m > 2047) m = 2047;
            if (v < 0) m = -m;
            if (m != 0) begin
                exp_q.push_back(mk(0, zeros, m));
                zeros = 0;
            end else begin
                zeros++;
            end
        end
        exp_q.push_back(mk(1, 0, 0));
    endtask

    task automatic cmp_q(input string nm);
        chk({nm, " beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s beat%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'd0;
    endtask

    // called at #1 after a rising edge with rdy high
    task automatic start(input int qs);
        en = 1'b1;
        qshift = 4'(qs);
        @(posedge clk); #1;
        en = 1'b0;
        qshift = 4'($urandom);
    endtask

    // gather beats until the EOB handshake; rmode 0 = ready held high,
    // otherwise random ready plus stray en pulses that must be ignored
    task automatic collect(input int rmode, input bit chk_cyc, input string nm);
        int busy;
        bit done, pv;
        beat_t b, pb;
        busy = 0; done = 0; pv = 0; pb = '0;
        got_q.delete();
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (!rdy) busy++;
            out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            en = (rmode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            b = '{eob: out_eob, run: out_run, level: out_level};
            if (pv) chk({nm, " hold"}, {out_valid, b}, {1'b1, pb});
            if (out_valid && out_ready) begin
                got_q.push_back(b);
                pv = 0;
                if (out_eob) begin
                    done = 1;
                    en = 1'b0;
                end
            end else begin
                pv = out_valid;
                pb = b;
            end
            @(posedge clk); #1;
        end
        en = 1'b0;
        out_ready = 1'b1;
        chk({nm, " eob_seen"}, done, 1);
        if (chk_cyc) chk({nm, " cycles"}, busy, 129 + exp_q.size() - 1);
        chk({nm, " rdy_back"}, rdy, 1);
    endtask

    vec_t tv[14];
    int a0, qs;

    initial begin
        tv = '{
            '{100, 2, 25},      '{32767, 0, 2047},  '{-32768, 0, -2047},
            '{-32768, 4, -2047}, '{-32768, 5, -1024}, '{4095, 1, 2047},
            '{4096, 1, 2047},   '{-7, 0, -7},       '{3, 2, 0},
            '{-3, 1, -1},       '{32767, 15, 0},    '{-1, 0, -1},
            '{2047, 0, 2047},   '{-2048, 0, -2047}
        };
        clear_mem();

        // reset values while reset is held
        #3;
        chk("rst rdy", rdy, 1);
        chk("rst outs", {out_valid, out_eob, out_run, out_level}, 0);
        chk("rst addr", addr, 0);
        #9 reset_n = 1'b1;
        @(posedge clk); #1;

        // all-zero block: EOB only
        start(0);
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 0));
        collect(0, 1, "allzero");
        cmp_q("allzero");

        // single coefficient at scan position 0 through the quantiser
        foreach (tv[i]) begin
            clear_mem();
            mem[0] = 16'(tv[i].coef);
            exp_q.delete();
            if (tv[i].lvl != 0) exp_q.push_back(mk(0, 0, tv[i].lvl));
            exp_q.push_back(mk(1, 0, 0));
            start(tv[i].qs);
            collect(0, 1, $sformatf("vec%0d", i));
            cmp_q($sformatf("vec%0d", i));
        end

        // scan order: raw address 8
        clear_mem();
        mem[8] = 16'hFFF9;
        exp_q.delete();
`ifdef QUANT_RLE_ZIGZAG_EN
        exp_q.push_back(mk(0, 2, -7));
`else
        exp_q.push_back(mk(0, 8, -7));
`endif
        exp_q.push_back(mk(1, 0, 0));
        start(0);
        collect(0, 1, "scan8");
        cmp_q("scan8");

        // both saturation directions back to back
        clear_mem();
        mem[0] = 16'h7FFF;
        mem[1] = 16'h8000;
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 2047));
        exp_q.push_back(mk(0, 0, -2047));
        exp_q.push_back(mk(1, 0, 0));
        start(0);
        collect(0, 1, "sat");
        cmp_q("sat");

        // backpressure: beat and address frozen for 10 stalled cycles
        clear_mem();
        mem[0] = 16'd5;
        out_ready = 1'b0;
        start(0);
        for (int k = 0; k < 20 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        a0 = addr;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("stall c%0d", k), {out_valid, out_eob, out_run, out_level, addr},
                {1'b1, 1'b0, 6'd0, 12'd5, 6'(a0)});
            @(posedge clk); #1;
        end
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 5));
        exp_q.push_back(mk(1, 0, 0));
        collect(0, 0, "stall");
        cmp_q("stall");

        // randomized blocks, some with the last coefficient forced nonzero
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 64; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
            if (blk % 3 == 0) mem[63] = 16'd1000;
            qs = $urandom_range(0, 6);
            model(qs);
            start(qs);
            collect(blk % 2, (blk % 2) == 0, $sformatf("rnd%0d", blk));
            cmp_q($sformatf("rnd%0d", blk));
        end

        // asynchronous reset during the fetch of scan index 20
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'd0;
        start(1);
        for (int k = 0; k < 400 && int'(addr) != tb_scan(20); k++) begin
            @(posedge clk); #1;
        end
        chk("arst busy", {rdy, addr}, {1'b0, 6'(tb_scan(20))});
        #1 reset_n = 1'b0;
        #1;
        chk("arst async", {rdy, out_valid, addr}, {1'b1, 1'b0, 6'd0});
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        chk("arst quiet", {rdy, out_valid}, {1'b1, 1'b0});
        model(3);
        start(3);
        collect(0, 1, "arst next");
        cmp_q("arst next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
